// File: rtl/divrec_pkg.sv
// Shared definitions for the divide_reconstruct block.
//   DEF_WIDTH : default operand width
//   state_t   : control states IDLE / RUN / DONE
package divrec_pkg;

  localparam int unsigned DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/divide_reconstruct.sv
// divide_reconstruct: rebuilds a dividend from quotient, remainder and divisor,
// Out_P = InQ*InB + InR, using a shift-add loop that handles one quotient bit
// per clock. The loop takes WIDTH cycles, then a one-cycle Done pulse follows.
//
// Ports
//   clk    : system clock, rising edge
//   rst    : synchronous active-high reset
//   Start  : request pulse; InQ/InR/InB are sampled on the same edge
//   InQ    : quotient operand (unsigned, WIDTH)
//   InR    : remainder operand (unsigned, WIDTH)
//   InB    : divisor operand (unsigned, WIDTH)
//   Out_P  : reconstructed dividend (2*WIDTH), held between completions
//   Busy   : high while iterating
//   Done   : one-cycle pulse when Out_P has just been updated
//   Err    : remainder-range flag (InR >= InB), only with REM_CHECK_EN
//
// Build option
//   REM_CHECK_EN : when defined, Err is captured at Start acceptance and held
//                  until the next acceptance or reset; otherwise Err is 0.
module divide_reconstruct
  import divrec_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               Start,
  input  logic [WIDTH-1:0]   InQ,
  input  logic [WIDTH-1:0]   InR,
  input  logic [WIDTH-1:0]   InB,
  output logic [2*WIDTH-1:0] Out_P,
  output logic               Busy,
  output logic               Done,
  output logic               Err
);

  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] q_q;     // quotient bits not yet consumed; LSB is Q[cnt]
  logic [PW-1:0]    b_q;     // divisor already shifted left by cnt
  logic [PW-1:0]    acc_q;
  logic             accept_c;
  logic             last_c;
  logic [PW-1:0]    acc_sum_c;

  // Start is honoured only outside RUN, so mid-run requests and operand
  // changes cannot disturb the iteration.
  always_comb begin
    accept_c = Start && ((state_q == IDLE) || (state_q == DONE));
  end

  // Single adder: add the pre-shifted divisor when the current quotient bit is set.
  always_comb begin
    acc_sum_c = acc_q + (q_q[0] ? b_q : '0);
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    last_c  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept_c) state_d = RUN;
      end
      RUN: begin
        if (cnt_q == CNT_LAST) begin
          last_c  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = accept_c ? RUN : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and status registers. Busy/Done are decoded from the next state
  // so they line up with state_q without a combinational output path.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      q_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      Out_P <= '0;
      Busy  <= 1'b0;
      Done  <= 1'b0;
    end else begin
      Busy <= (state_d == RUN);
      Done <= (state_d == DONE);
      if (accept_c) begin
        q_q   <= InQ;
        b_q   <= PW'(InB);
        acc_q <= PW'(InR);
        cnt_q <= '0;
      end else if (state_q == RUN) begin
        acc_q <= acc_sum_c;
        q_q   <= q_q >> 1;
        b_q   <= b_q << 1;
        cnt_q <= cnt_q + CNT_W'(1);
        if (last_c) Out_P <= acc_sum_c;
      end
    end
  end

`ifdef REM_CHECK_EN
  // Remainder must be strictly below the divisor for a valid division result.
  always_ff @(posedge clk) begin
    if (rst) begin
      Err <= 1'b0;
    end else if (accept_c) begin
      Err <= (InR >= InB);
    end
  end
`else
  assign Err = 1'b0;
`endif

endmodule

// File: tb/tb_divide_reconstruct.sv
// Bench for divide_reconstruct: directed cases with literal expectations plus
// randomized traffic, all checked every cycle against an arithmetic model.
module tb_divide_reconstruct;

  localparam int unsigned W  = 8;
  localparam int unsigned PW = 2 * W;
`ifdef REM_CHECK_EN
  localparam bit REM_CHK = 1'b1;
`else
  localparam bit REM_CHK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          Start;
  logic [W-1:0]  InQ;
  logic [W-1:0]  InR;
  logic [W-1:0]  InB;
  logic [PW-1:0] Out_P;
  logic          Busy;
  logic          Done;
  logic          Err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  divide_reconstruct #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .Start (Start),
    .InQ   (InQ),
    .InR   (InR),
    .InB   (InB),
    .Out_P (Out_P),
    .Busy  (Busy),
    .Done  (Done),
    .Err   (Err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: remaining busy cycles, and the product latched at accept.
  int     m_rem = 0;
  bit     m_done = 1'b0;
  bit     m_err = 1'b0;
  longint m_out = 0;
  longint m_res = 0;
  bit     model_en = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_rem  = 0;
      m_done = 1'b0;
      m_out  = 0;
      m_err  = 1'b0;
    end else if (m_rem > 0) begin
      m_rem  = m_rem - 1;
      m_done = (m_rem == 0);
      if (m_done) m_out = m_res;
    end else begin
      m_done = 1'b0;
      if (Start) begin
        m_rem = W;
        m_res = longint'(InQ) * longint'(InB) + longint'(InR);
        m_err = REM_CHK && (InR >= InB);
      end
    end
  end

  // Compare every cycle on the falling edge.
  always @(negedge clk) begin
    if (model_en) begin
      chk("busy",  64'(Busy),  64'(m_rem > 0));
      chk("done",  64'(Done),  64'(m_done));
      chk("out_p", 64'(Out_P), 64'(m_out));
      chk("err",   64'(Err),   64'(m_err));
      if (Busy && Done) chk("busy_done_exclusive", 64'(1), 64'(0));
    end
  end

  function automatic logic [W-1:0] pick();
    int sel;
    sel = int'($urandom_range(0, 5));
    if (sel == 0) return '0;
    if (sel == 1) return '1;
    return W'($urandom);
  endfunction

  // Issue one operation from a falling edge and wait (bounded) for Done.
  task automatic run_op(input logic [W-1:0] q, input logic [W-1:0] r, input logic [W-1:0] b,
                        input longint exp, input string name);
    int busy_n;
    bit seen;
    busy_n = 0;
    seen   = 1'b0;
    InQ = q; InR = r; InB = b; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    InQ = W'($urandom); InR = W'($urandom); InB = W'($urandom);
    for (int i = 0; i < 40 && !seen; i++) begin
      if (Busy) busy_n++;
      if (Done) seen = 1'b1;
      else @(negedge clk);
    end
    chk({name, "_done_seen"}, 64'(seen), 64'(1));
    chk({name, "_out"}, 64'(Out_P), 64'(exp));
    chk({name, "_model"}, 64'(m_out), 64'(exp));
    chk({name, "_busy_cycles"}, 64'(busy_n), 64'(W));
  endtask

  initial begin
    int     dones;
    longint cap;
    rst = 1'b1; Start = 1'b0; InQ = '0; InR = '0; InB = '0;
    repeat (2) @(negedge clk);
    model_en = 1'b1;
    chk("reset_out",  64'(Out_P), 64'(0));
    chk("reset_busy", 64'(Busy),  64'(0));
    chk("reset_done", 64'(Done),  64'(0));
    chk("reset_err",  64'(Err),   64'(0));
    rst = 1'b0;
    @(negedge clk);

    run_op(8'd17,  8'd0,   8'd15,  255,   "q17_b15");
    run_op(8'd65,  8'd1,   8'd2,   131,   "q65_b2");
    run_op(8'd23,  8'd4,   8'd7,   165,   "q23_b7");
    run_op(8'd255, 8'd255, 8'd255, 65280, "max_ops");
    run_op(8'd36,  8'd0,   8'd7,   252,   "q36_b7");
    run_op(8'd5,   8'd3,   8'd0,   3,     "b_zero");
    run_op(8'd0,   8'd200, 8'd9,   200,   "q_zero");
    run_op(8'd10,  8'd9,   8'd7,   79,    "rem_range");
    chk("rem_range_err", 64'(Err), 64'(REM_CHK));
    @(negedge clk);

    // Start during RUN is ignored; exactly one Done with the original result.
    InQ = 8'd200; InR = 8'd5; InB = 8'd3; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    repeat (2) @(negedge clk);
    InQ = 8'd1; InR = 8'd0; InB = 8'd1; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    dones = 0; cap = -1;
    for (int i = 0; i < 20; i++) begin
      if (Done) begin dones++; cap = longint'(Out_P); end
      @(negedge clk);
    end
    chk("midrun_start_dones", 64'(dones), 64'(1));
    chk("midrun_start_out", 64'(cap), 64'(605));

    // Reset in the middle of RUN aborts: no Done, Out_P cleared.
    InQ = 8'd50; InR = 8'd7; InB = 8'd9; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 64'(Busy), 64'(0));
    chk("abort_out", 64'(Out_P), 64'(0));
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      if (Done) dones++;
      @(negedge clk);
    end
    chk("abort_no_done", 64'(dones), 64'(0));
    run_op(8'd3, 8'd1, 8'd4, 13, "after_abort");

    // Reset wins over Start on the same edge.
    InQ = 8'd9; InR = 8'd1; InB = 8'd9; Start = 1'b1; rst = 1'b1;
    @(negedge clk);
    Start = 1'b0; rst = 1'b0;
    chk("rst_over_start_busy", 64'(Busy), 64'(0));

    // Randomized traffic, including back-to-back starts and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 199) == 0);
      Start = ($urandom_range(0, 3) == 0);
      InQ   = pick();
      InR   = pick();
      InB   = pick();
      @(negedge clk);
    end

    rst = 1'b0; Start = 1'b0;
    repeat (2 * W + 4) @(negedge clk);
    model_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
